// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared types, sizes and enable encodings for the 3-to-8 decoder scan sequencer
package scan_pkg;

  localparam int NUM_LINES = 8;
  localparam int ADDR_W    = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } scan_state_e;

  typedef struct packed {
    logic g1;
    logic g2a_n;
    logic g2b_n;
  } scan_en_t;

  localparam scan_en_t EN_ON  = '{g1: 1'b1, g2a_n: 1'b0, g2b_n: 1'b0};
  localparam scan_en_t EN_OFF = '{g1: 1'b0, g2a_n: 1'b1, g2b_n: 1'b1};

  function automatic logic [ADDR_W-1:0] lowest_line(input logic [NUM_LINES-1:0] mask);
    logic [ADDR_W-1:0] r;
    r = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (!mask[i]) r = ADDR_W'(i);
    end
    return r;
  endfunction

  function automatic logic [ADDR_W-1:0] highest_line(input logic [NUM_LINES-1:0] mask);
    logic [ADDR_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (!mask[i]) r = ADDR_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/scan_next_line.sv
// rtl/scan_next_line.sv - combinational priority finder for the next, lowest and last enabled decoder line
module scan_next_line
  import scan_pkg::*;
(
  input  logic [ADDR_W-1:0]    addr,
  input  logic [NUM_LINES-1:0] mask,
  output logic [ADDR_W-1:0]    next_addr,
  output logic [ADDR_W-1:0]    low_addr,
  output logic                 is_last,
  output logic                 none
);

  // Descending scan so the smallest enabled index above addr is the final assignment.
  always_comb begin
    next_addr = addr;
    is_last   = 1'b1;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (!mask[i] && (i > int'(addr))) begin
        next_addr = ADDR_W'(i);
        is_last   = 1'b0;
      end
    end
  end

  assign low_addr = lowest_line(mask);
  assign none     = &mask;

endmodule

// File: rtl/scan_seq_138.sv
// rtl/scan_seq_138.sv - 3-to-8 decoder line scan sequencer; SCAN_MASK_EN adds the per-line skip mask port
module scan_seq_138
  import scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [DWELL_W-1:0] dwell,
`ifdef SCAN_MASK_EN
  input  logic [NUM_LINES-1:0] mask,
`endif
  output logic [ADDR_W-1:0]  addr,
  output logic               en_g1,
  output logic               en_g2a_n,
  output logic               en_g2b_n,
  output logic               busy,
  output logic               line_done,
  output logic               frame_done
);

  logic [NUM_LINES-1:0] mask_in;
`ifdef SCAN_MASK_EN
  assign mask_in = mask;
`else
  assign mask_in = '0;
`endif

  scan_state_e          state;
  logic [DWELL_W-1:0]   cnt;
  logic [DWELL_W-1:0]   dwell_q;
  logic [NUM_LINES-1:0] mask_q;
  logic                 stop_flag;
  logic                 leave_q;

  logic [NUM_LINES-1:0] mask_sel;
  logic [ADDR_W-1:0]    nxt_addr;
  logic [ADDR_W-1:0]    low_addr;
  logic                 is_last;
  logic                 none;
  logic [ADDR_W-1:0]    wrap_low;
  logic                 wrap_none;
  logic                 stop_now;

  // While idle the finder looks at the live mask so a start can pick its first line.
  assign mask_sel  = (state == IDLE) ? mask_in : mask_q;
  assign wrap_low  = lowest_line(mask_in);
  assign wrap_none = &mask_in;
  assign stop_now  = stop_flag | stop;

  scan_next_line u_next_line (
    .addr      (addr),
    .mask      (mask_sel),
    .next_addr (nxt_addr),
    .low_addr  (low_addr),
    .is_last   (is_last),
    .none      (none)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state                        <= IDLE;
      addr                         <= '0;
      {en_g1, en_g2a_n, en_g2b_n}  <= EN_OFF;
      busy                         <= 1'b0;
      line_done                    <= 1'b0;
      frame_done                   <= 1'b0;
      stop_flag                    <= 1'b0;
      leave_q                      <= 1'b0;
      cnt                          <= '0;
      dwell_q                      <= '0;
      mask_q                       <= '0;
    end else begin
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      if (busy && stop) stop_flag <= 1'b1;

      case (state)
        IDLE: begin
          if (start && !none) begin
            state                       <= ACTIVE;
            busy                        <= 1'b1;
            addr                        <= low_addr;
            dwell_q                     <= dwell;
            mask_q                      <= mask_in;
            cnt                         <= dwell;
            stop_flag                   <= stop;
            {en_g1, en_g2a_n, en_g2b_n} <= EN_ON;
            line_done                   <= (dwell == '0);
            frame_done                  <= (dwell == '0) && (low_addr == highest_line(mask_in));
          end
        end

        ACTIVE: begin
          if (cnt != '0) begin
            cnt <= cnt - DWELL_W'(1);
            if (cnt == DWELL_W'(1)) begin
              line_done  <= 1'b1;
              frame_done <= is_last;
            end
          end else begin
            state                       <= GAP;
            {en_g1, en_g2a_n, en_g2b_n} <= EN_OFF;
            if (stop_now || (is_last && !cont)) begin
              leave_q <= 1'b1;
            end else if (is_last) begin
              // Wrap to a new frame: re-latch parameters; an all-masked reload ends the run.
              if (wrap_none) begin
                leave_q <= 1'b1;
              end else begin
                leave_q <= 1'b0;
                addr    <= wrap_low;
                dwell_q <= dwell;
                mask_q  <= mask_in;
              end
            end else begin
              leave_q <= 1'b0;
              addr    <= nxt_addr;
            end
          end
        end

        GAP: begin
          if (leave_q) begin
            state     <= IDLE;
            busy      <= 1'b0;
            stop_flag <= 1'b0;
            leave_q   <= 1'b0;
          end else begin
            state                       <= ACTIVE;
            {en_g1, en_g2a_n, en_g2b_n} <= EN_ON;
            cnt                         <= dwell_q;
            line_done                   <= (dwell_q == '0);
            frame_done                  <= (dwell_q == '0) && is_last;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_seq_138.sv
// tb/tb_scan_seq_138.sv - directed-vector bench for scan_seq_138 (mask vectors only with SCAN_MASK_EN)
module tb_scan_seq_138;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       cont;
  logic [7:0] dwell;
  logic [7:0] mask;
  logic [2:0] addr;
  logic       en_g1;
  logic       en_g2a_n;
  logic       en_g2b_n;
  logic       busy;
  logic       line_done;
  logic       frame_done;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  scan_seq_138 #(.DWELL_W(8)) dut (
`ifdef SCAN_MASK_EN
    .mask       (mask),
`endif
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .cont       (cont),
    .dwell      (dwell),
    .addr       (addr),
    .en_g1      (en_g1),
    .en_g2a_n   (en_g2a_n),
    .en_g2b_n   (en_g2b_n),
    .busy       (busy),
    .line_done  (line_done),
    .frame_done (frame_done)
  );

  // {busy, addr, g1, g2a_n, g2b_n, line_done, frame_done}
  logic [8:0] obs;
  assign obs = {busy, addr, en_g1, en_g2a_n, en_g2b_n, line_done, frame_done};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called in the first active cycle; returns in the cycle after the gap.
  task automatic run_line(input logic [2:0] a, input int d, input logic last, input logic [2:0] nxt);
    for (int c = 0; c <= d; c++) begin
      check("active", obs, {1'b1, a, 3'b100, (c == d), ((c == d) && last)});
      @(negedge clk);
    end
    check("gap", obs, {1'b1, nxt, 3'b011, 2'b00});
    @(negedge clk);
  endtask

  task automatic expect_idle(input string tag, input logic [2:0] a);
    check(tag, obs, {1'b0, a, 3'b011, 2'b00});
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    cont  = 1'b0;
    dwell = 8'd0;
    mask  = 8'h00;
    repeat (3) @(negedge clk);
    expect_idle("reset", 3'd0);
    rst = 1'b0;
    @(negedge clk);
    expect_idle("post_reset", 3'd0);

    // Single frame, dwell 2; a start pulse during line 3 must be ignored.
    dwell = 8'd2;
    cont  = 1'b0;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      start = (i == 3);
      run_line(3'(i), 2, (i == 7), (i == 7) ? 3'd7 : 3'(i + 1));
    end
    start = 1'b0;
    expect_idle("single_end", 3'd7);
    @(negedge clk);
    expect_idle("single_hold", 3'd7);

    // Continuous, dwell 0: wrap after line 7, stop during line 3 of frame 2.
    dwell = 8'd0;
    cont  = 1'b1;
    pulse_start();
    for (int i = 0; i < 8; i++) run_line(3'(i), 0, (i == 7), (i == 7) ? 3'd0 : 3'(i + 1));
    for (int i = 0; i < 3; i++) run_line(3'(i), 0, 1'b0, 3'(i + 1));
    stop = 1'b1;
    run_line(3'd3, 0, 1'b0, 3'd3);
    stop = 1'b0;
    expect_idle("cont_stop", 3'd3);

    // Stop in the last cycle of a frame with cont=1 ends after that gap.
    pulse_start();
    for (int i = 0; i < 7; i++) run_line(3'(i), 0, 1'b0, 3'(i + 1));
    stop = 1'b1;
    run_line(3'd7, 0, 1'b1, 3'd7);
    stop = 1'b0;
    expect_idle("stop_last", 3'd7);
    cont = 1'b0;

    // Start and stop together, maximum dwell: one 256-cycle line, then idle.
    dwell = 8'hFF;
    stop  = 1'b1;
    pulse_start();
    stop = 1'b0;
    run_line(3'd0, 255, 1'b0, 3'd0);
    expect_idle("start_stop_max", 3'd0);

`ifdef SCAN_MASK_EN
    dwell = 8'd1;
    mask  = 8'b1010_0101;
    pulse_start();
    run_line(3'd1, 1, 1'b0, 3'd3);
    run_line(3'd3, 1, 1'b0, 3'd4);
    run_line(3'd4, 1, 1'b0, 3'd6);
    run_line(3'd6, 1, 1'b1, 3'd6);
    expect_idle("mask_end", 3'd6);
    mask = 8'hFF;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      expect_idle("mask_all", 3'd6);
      @(negedge clk);
    end
    mask = 8'h00;
`endif

    // Reset held three cycles in the middle of a continuous run.
    dwell = 8'd3;
    cont  = 1'b1;
    pulse_start();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_idle("rst_mid", 3'd0);
    end
    rst  = 1'b0;
    cont = 1'b0;
    @(negedge clk);
    expect_idle("rst_release", 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
